calc_cmd_enc: RTL and testbench

CALC_CMD_ENC -- requirements
Module: calc_cmd_enc

---
 rtl/calc_cmd_enc.sv | 164 ++++++++++++++++
 tb/tb_calc_cmd_enc.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/calc_cmd_enc.sv
// calc_cmd_enc: turns raw operation-select buttons and a commit button into a
// registered ALU opcode with a valid/ready handshake.
//
// Ports
//   clk       : single clock, all state updates on its rising edge
//   reset     : synchronous, active-high reset
//   btnl/r/d  : raw asynchronous operation-select buttons
//   btnc      : raw asynchronous commit button
//   op_ready  : consumer accepts alu_op when op_valid && op_ready
//   alu_op    : registered encoded operation (bits above 3 are always 0)
//   op_valid  : registered, an operation is pending
//   op_drop   : one-cycle pulse, a commit was discarded while busy
//   op_seq    : count of accepted transfers, wraps at 16
//
// LATCH_MODE=1 captures on a debounced btnc rising edge and holds the code
// until accepted. LATCH_MODE=0 streams the registered encode of the selects
// every cycle and ignores btnc and op_ready.

module calc_cmd_enc #(
   parameter int unsigned DEB_CYCLES = 4,
   parameter int unsigned OP_W       = 4,
   parameter int unsigned LATCH_MODE = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            btnl,
   input  logic            btnr,
   input  logic            btnd,
   input  logic            btnc,
   input  logic            op_ready,
   output logic [OP_W-1:0] alu_op,
   output logic            op_valid,
   output logic            op_drop,
   output logic [3:0]      op_seq
);

   localparam int unsigned CNT_W = 8;
   localparam int unsigned NBTN  = 4;
   // Flip happens on the edge that closes the DEB_CYCLES-th mismatched cycle.
   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

   // Button vector order: [3]=c, [2]=l, [1]=r, [0]=d
   logic [NBTN-1:0]  raw;
   logic [NBTN-1:0]  sync1;
   logic [NBTN-1:0]  sync2;
   logic [NBTN-1:0]  deb;
   logic [CNT_W-1:0] cnt [NBTN];
   logic             prev_c;
   logic [3:0]       code_c;
   logic             commit_c;

   assign raw = {btnc, btnl, btnr, btnd};

   // Opcode table indexed by debounced {l,r,d}
   function automatic logic [3:0] encode(input logic [2:0] sel);
      logic [3:0] code;
      case (sel)
         3'b000:  code = 4'b0000;
         3'b001:  code = 4'b0001;
         3'b010:  code = 4'b0100;
         3'b011:  code = 4'b0101;
         3'b100:  code = 4'b0110;
         3'b101:  code = 4'b1010;
         3'b110:  code = 4'b1011;
         default: code = 4'b1100;
      endcase
      return code;
   endfunction

   // Two-flop synchroniser per button
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

   // Per-button debouncer; counter tracks consecutive mismatched cycles
   always_ff @(posedge clk) begin
      if (reset) begin
         deb    <= '0;
         prev_c <= 1'b0;
         for (int i = 0; i < NBTN; i++) cnt[i] <= '0;
      end else begin
         prev_c <= deb[3];
         for (int i = 0; i < NBTN; i++) begin
            if (sync2[i] == deb[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == DEB_LAST) begin
               deb[i] <= sync2[i];
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   assign code_c   = encode(deb[2:0]);
   assign commit_c = deb[3] & ~prev_c;

   generate
      if (LATCH_MODE != 0) begin : g_latch
         typedef enum logic {IDLE, PEND} state_t;
         state_t state;

         // Commit/handshake controller; op_valid mirrors state == PEND
         always_ff @(posedge clk) begin
            if (reset) begin
               state    <= IDLE;
               alu_op   <= '0;
               op_valid <= 1'b0;
               op_drop  <= 1'b0;
               op_seq   <= '0;
            end else begin
               op_drop <= 1'b0;
               if (op_valid && op_ready) op_seq <= op_seq + 4'd1;
               case (state)
                  IDLE: begin
                     if (commit_c) begin
                        alu_op   <= OP_W'(code_c);
                        op_valid <= 1'b1;
                        state    <= PEND;
                     end
                  end
                  PEND: begin
                     if (op_ready) begin
                        // Back-to-back: accept and recapture with no idle cycle
                        if (commit_c) begin
                           alu_op <= OP_W'(code_c);
                        end else begin
                           op_valid <= 1'b0;
                           state    <= IDLE;
                        end
                     end else if (commit_c) begin
                        op_drop <= 1'b1;
                     end
                  end
                  default: begin
                     state    <= IDLE;
                     op_valid <= 1'b0;
                  end
               endcase
            end
         end
      end else begin : g_live
         // Live level mode: registered encode every cycle, handshake held idle
         always_ff @(posedge clk) begin
            if (reset) begin
               alu_op <= '0;
            end else begin
               alu_op <= OP_W'(code_c);
            end
            op_valid <= 1'b0;
            op_drop  <= 1'b0;
            op_seq   <= '0;
         end
      end
   endgenerate

endmodule

// File: tb/tb_calc_cmd_enc.sv
// tb_calc_cmd_enc: directed bench for calc_cmd_enc with DEB_CYCLES=4, OP_W=4.
// One instance in commit/handshake mode, one in live level mode sharing inputs.

module tb_calc_cmd_enc;

   logic       clk = 1'b0;
   logic       reset;
   logic       btnl, btnr, btnd, btnc, op_ready;
   logic [3:0] alu_op, live_op;
   logic       op_valid, op_drop, live_valid, live_drop;
   logic [3:0] op_seq, live_seq;

   int checks = 0;
   int passed = 0;
   int drop_cnt = 0;
   int live_bad = 0;
   int seq_exp;

   always #5 clk = ~clk;

   calc_cmd_enc #(.DEB_CYCLES(4), .OP_W(4), .LATCH_MODE(1)) dut (
      .clk(clk), .reset(reset), .btnl(btnl), .btnr(btnr), .btnd(btnd),
      .btnc(btnc), .op_ready(op_ready), .alu_op(alu_op), .op_valid(op_valid),
      .op_drop(op_drop), .op_seq(op_seq)
   );

   calc_cmd_enc #(.DEB_CYCLES(4), .OP_W(4), .LATCH_MODE(0)) dut_live (
      .clk(clk), .reset(reset), .btnl(btnl), .btnr(btnr), .btnd(btnd),
      .btnc(btnc), .op_ready(op_ready), .alu_op(live_op), .op_valid(live_valid),
      .op_drop(live_drop), .op_seq(live_seq)
   );

   // Count drop pulses (each one-cycle pulse is seen once) and live-mode handshake activity
   always @(negedge clk) begin
      if (op_drop) drop_cnt++;
      if (live_valid || live_drop || live_seq != 4'd0) live_bad++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Advance n rising edges; inputs change and outputs are sampled 1 time unit after
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic set_sel(input logic [2:0] s);
      {btnl, btnr, btnd} = s;
   endtask

   initial begin
      reset = 1'b1; btnl = 0; btnr = 0; btnd = 0; btnc = 0; op_ready = 0;
      step(3);
      check("rst_alu_op", alu_op, 4'b0000);
      check("rst_valid", op_valid, 1'b0);
      check("rst_drop", op_drop, 1'b0);
      check("rst_seq", op_seq, 4'd0);
      check("rst_live_op", live_op, 4'b0000);
      reset = 1'b0;
      step(2);

      // Basic capture, latency 7 edges, single transfer
      set_sel(3'b101);
      step(10);
      btnc = 1'b1;
      step(6);
      check("lat_edge6_valid", op_valid, 1'b0);
      step(1);
      check("lat_edge7_valid", op_valid, 1'b1);
      check("cap_101_op", alu_op, 4'b1010);
      op_ready = 1'b1;
      step(1);
      op_ready = 1'b0;
      check("xfer1_valid", op_valid, 1'b0);
      check("xfer1_seq", op_seq, 4'd1);
      check("xfer1_op_hold", alu_op, 4'b1010);
      btnc = 1'b0;
      set_sel(3'b000);
      step(10);

      // Short btnc glitch is filtered
      btnc = 1'b1;
      step(3);
      btnc = 1'b0;
      step(12);
      check("glitch_valid", op_valid, 1'b0);
      check("glitch_drop", drop_cnt, 0);

      // Commit while busy is dropped, held code unchanged
      set_sel(3'b010);
      step(8);
      btnc = 1'b1;
      step(10);
      check("pend_010_op", alu_op, 4'b0100);
      check("pend_010_valid", op_valid, 1'b1);
      btnc = 1'b0;
      step(8);
      set_sel(3'b110);
      step(8);
      btnc = 1'b1;
      step(10);
      check("drop_once", drop_cnt, 1);
      check("drop_op_hold", alu_op, 4'b0100);
      check("drop_valid_hold", op_valid, 1'b1);
      check("drop_seq_hold", op_seq, 4'd1);

      // Accept and recapture in the same cycle
      btnc = 1'b0;
      step(8);
      set_sel(3'b111);
      step(8);
      btnc = 1'b1;
      step(6);
      check("b2b_pre_op", alu_op, 4'b0100);
      op_ready = 1'b1;
      step(1);
      op_ready = 1'b0;
      check("b2b_valid", op_valid, 1'b1);
      check("b2b_op", alu_op, 4'b1100);
      check("b2b_seq", op_seq, 4'd2);
      check("b2b_no_drop", drop_cnt, 1);

      // Accept pending, then 13 more transfers for 16 total -> wrap to 0
      op_ready = 1'b1;
      step(1);
      op_ready = 1'b0;
      check("seq3", op_seq, 4'd3);
      btnc = 1'b0;
      step(8);
      seq_exp = 3;
      for (int k = 0; k < 13; k++) begin
         btnc = 1'b1;
         step(8);
         op_ready = 1'b1;
         step(1);
         op_ready = 1'b0;
         btnc = 1'b0;
         step(7);
         seq_exp = (seq_exp + 1) % 16;
      end
      check("seq_model", op_seq, 4'(seq_exp));
      check("seq_wrap", op_seq, 4'd0);

      // Reset while pending discards without counting a transfer
      btnc = 1'b1;
      step(8);
      check("pre_rst_valid", op_valid, 1'b1);
      reset = 1'b1;
      op_ready = 1'b1;
      step(1);
      reset = 1'b0;
      op_ready = 1'b0;
      check("pend_rst_valid", op_valid, 1'b0);
      check("pend_rst_op", alu_op, 4'b0000);
      check("pend_rst_seq", op_seq, 4'd0);

      // btnc still held after release is a fresh press
      step(6);
      check("held_edge6_valid", op_valid, 1'b0);
      step(1);
      check("held_edge7_valid", op_valid, 1'b1);
      check("held_op", alu_op, 4'b1100);
      op_ready = 1'b1;
      step(1);
      op_ready = 1'b0;
      check("held_xfer_seq", op_seq, 4'd1);

      // Selects change under held btnc: no capture; live mode follows in 7 edges
      check("live_pre_op", live_op, 4'b1100);
      set_sel(3'b110);
      step(6);
      check("live_edge6_op", live_op, 4'b1100);
      step(1);
      check("live_edge7_op", live_op, 4'b1011);
      step(10);
      check("nocap_valid", op_valid, 1'b0);
      check("nocap_op_hold", alu_op, 4'b1100);
      check("live_handshake_idle", live_bad, 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
